// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: luma coefficients and the pixel tag
// that travels with every beat between reader, grayscale and writer stages.
package img_pkg;

    localparam int KR    = 77;
    localparam int KG    = 150;
    localparam int KB    = 29;
    localparam int ROUND = 128;

    localparam int TAG_W = 16;

    typedef struct packed {
        logic [TAG_W-1:0] col;
        logic [TAG_W-1:0] row;
        logic             sof;
        logic             eol;
        logic             eof;
    } pix_tag_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order column/row counter with frame tags; force_origin retags the
// current beat as (0,0) and restarts counting after it.
module raster_counter #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    input  logic          force_origin,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          sof,
    output logic          eol,
    output logic          eof,
    output logic          at_origin
);

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          w_row_last;

    assign col        = force_origin ? '0 : r_col;
    assign row        = force_origin ? '0 : r_row;
    assign w_row_last = (row == ROW_LAST);
    assign eol        = (col == COL_LAST);
    assign eof        = eol && w_row_last;
    assign sof        = (col == '0) && (row == '0);
    assign at_origin  = (r_col == '0) && (r_row == '0);

    // Next position is derived from the effective (possibly forced) tag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (advance) begin
            if (eol) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : row + RW'(1);
            end else begin
                r_col <= col + CW'(1);
                r_row <= row;
            end
        end
    end

endmodule

// File: rtl/rgb_gray_stream.sv
// RGB to 8-bit luma streaming stage: input register, product stage and
// rounding-sum stage, all stalled together by downstream backpressure.
module rgb_gray_stream
    import img_pkg::*;
#(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int DW     = 8,
    parameter int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_r,
    input  logic [DW-1:0] s_g,
    input  logic [DW-1:0] s_b,
    input  logic          s_sof,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_gray,
    output logic [CW-1:0] m_col,
    output logic [RW-1:0] m_row,
    output logic          m_sof,
    output logic          m_eol,
    output logic          m_eof,
    output logic          frame_done,
    output logic          resync_err
);

    localparam int PW = 2 * DW;

    logic          w_en;
    logic          w_acc;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_sof;
    logic          w_eol;
    logic          w_eof;
    logic          w_at_origin;
    pix_tag_t      w_tag;
    logic [PW-1:0] w_sum;
    logic          w_unused;

    logic          r_v0;
    logic          r_v1;
    logic          r_v2;
    pix_tag_t      r_tag0;
    pix_tag_t      r_tag1;
    pix_tag_t      r_tag2;
    logic [DW-1:0] r_r;
    logic [DW-1:0] r_g;
    logic [DW-1:0] r_b;
    logic [PW-1:0] r_pr;
    logic [PW-1:0] r_pg;
    logic [PW-1:0] r_pb;
    logic [DW-1:0] r_gray;
    logic          r_done;

    assign w_en    = !r_v2 || m_ready;
    assign s_ready = w_en;
    assign w_acc   = s_valid && w_en;

    raster_counter #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .CW    (CW),
        .RW    (RW)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .advance     (w_acc),
        .force_origin(s_sof),
        .col         (w_col),
        .row         (w_row),
        .sof         (w_sof),
        .eol         (w_eol),
        .eof         (w_eof),
        .at_origin   (w_at_origin)
    );

    assign resync_err = w_acc && s_sof && !w_at_origin;

    always_comb begin
        w_tag     = '0;
        w_tag.col = TAG_W'(w_col);
        w_tag.row = TAG_W'(w_row);
        w_tag.sof = w_sof;
        w_tag.eol = w_eol;
        w_tag.eof = w_eof;
    end

    // Coefficients sum to 256, so the rounded sum never exceeds 16 bits
    assign w_sum = r_pr + r_pg + r_pb + PW'(ROUND);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0   <= 1'b0;
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_tag0 <= '0;
            r_tag1 <= '0;
            r_tag2 <= '0;
            r_r    <= '0;
            r_g    <= '0;
            r_b    <= '0;
            r_pr   <= '0;
            r_pg   <= '0;
            r_pb   <= '0;
            r_gray <= '0;
        end else if (w_en) begin
            r_v0   <= s_valid;
            r_tag0 <= w_tag;
            r_r    <= s_r;
            r_g    <= s_g;
            r_b    <= s_b;
            r_v1   <= r_v0;
            r_tag1 <= r_tag0;
            r_pr   <= PW'(KR) * PW'(r_r);
            r_pg   <= PW'(KG) * PW'(r_g);
            r_pb   <= PW'(KB) * PW'(r_b);
            r_v2   <= r_v1;
            r_tag2 <= r_tag1;
            r_gray <= w_sum[PW-1:DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= r_v2 && m_ready && r_tag2.eof;
        end
    end

    assign m_valid    = r_v2;
    assign m_gray     = r_gray;
    assign m_col      = r_tag2.col[CW-1:0];
    assign m_row      = r_tag2.row[RW-1:0];
    assign m_sof      = r_tag2.sof;
    assign m_eol      = r_tag2.eol;
    assign m_eof      = r_tag2.eof;
    assign frame_done = r_done;
    assign w_unused   = ^{r_tag2.col, r_tag2.row};

endmodule
